// File: rtl/instruction_fetch_switch.sv
// Fetch stage that runs from BIOS memory and then switches to OS memory after a fixed bubble.
// PC and INSTRUCTION are registered (word appears one cycle after its PC); STALL freezes both.
module instruction_fetch_switch #(
   parameter int                    DATA_WIDTH         = 32,
   parameter int                    ADDR_WIDTH         = 10,
   parameter logic [ADDR_WIDTH-1:0] BIOS_ENTRY_ADDRESS = '0,
   parameter logic [ADDR_WIDTH-1:0] OS_ENTRY_ADDRESS   = '0,
   parameter int                    FLUSH_CYCLES       = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION    = '0
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic                  instruction_selection,
   input  logic [DATA_WIDTH-1:0] BIOS_INSTRUCTION,
   input  logic [DATA_WIDTH-1:0] OS_INSTRUCTION,
   input  logic                  STALL,
   input  logic                  BRANCH_TAKEN,
   input  logic [ADDR_WIDTH-1:0] BRANCH_TARGET,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] INSTRUCTION,
   output logic                  INSTRUCTION_VALID,
   output logic [5:0]            BIOS_INSTRUCTION_OPCODE,
   output logic                  HANDOFF_BUSY,
   output logic                  HANDOFF_DONE
);

   typedef enum logic [1:0] {
      BIOS_RUN = 2'd0,
      FLUSH    = 2'd1,
      OS_RUN   = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_nxt;
   logic [DATA_WIDTH-1:0]   instr_q, instr_nxt;
   logic                    vld_q, vld_nxt;
   logic [3:0]              cnt_q, cnt_nxt;
   logic                    done_q, done_nxt;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= BIOS_RUN;
         pc_q    <= BIOS_ENTRY_ADDRESS;
         instr_q <= NOP_INSTRUCTION;
         vld_q   <= 1'b0;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         vld_q   <= vld_nxt;
         cnt_q   <= cnt_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      vld_nxt   = vld_q;
      cnt_nxt   = cnt_q;
      done_nxt  = 1'b0;
      case (state)
         BIOS_RUN, OS_RUN: begin
            // Handoff request overrides stall and branch in the cycle it is seen.
            if (state == BIOS_RUN && instruction_selection) begin
               state_nxt = FLUSH;
               pc_nxt    = OS_ENTRY_ADDRESS;
               cnt_nxt   = FLUSH_CNT_INIT;
               instr_nxt = NOP_INSTRUCTION;
               vld_nxt   = 1'b0;
            end else if (!STALL) begin
               if (BRANCH_TAKEN) begin
                  pc_nxt    = BRANCH_TARGET;
                  instr_nxt = NOP_INSTRUCTION;
                  vld_nxt   = 1'b0;
               end else begin
                  pc_nxt    = pc_q + ADDR_WIDTH'(1);
                  instr_nxt = (state == OS_RUN) ? OS_INSTRUCTION : BIOS_INSTRUCTION;
                  vld_nxt   = 1'b1;
               end
            end
         end
         FLUSH: begin
            pc_nxt    = OS_ENTRY_ADDRESS;
            instr_nxt = NOP_INSTRUCTION;
            vld_nxt   = 1'b0;
            if (cnt_q == 4'd0) begin
               state_nxt = OS_RUN;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         default: state_nxt = BIOS_RUN;
      endcase
   end

   assign PC                      = pc_q;
   assign INSTRUCTION             = instr_q;
   assign INSTRUCTION_VALID       = vld_q;
   assign HANDOFF_BUSY            = (state == FLUSH);
   assign HANDOFF_DONE            = done_q;
   assign BIOS_INSTRUCTION_OPCODE = BIOS_INSTRUCTION[DATA_WIDTH-1 -: 6];

endmodule

// File: tb/tb_instruction_fetch_switch.sv
// Directed bench: expected outputs are queued per cycle and checked by a separate monitor.
module tb_instruction_fetch_switch;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        sel = 1'b0;
   logic        STALL = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [9:0]  BRANCH_TARGET = '0;
   logic [5:0]  bios_op = '0;
   logic [31:0] BIOS_INSTRUCTION, OS_INSTRUCTION;
   logic [9:0]  PC;
   logic [31:0] INSTRUCTION;
   logic        INSTRUCTION_VALID, HANDOFF_BUSY, HANDOFF_DONE;
   logic [5:0]  BIOS_INSTRUCTION_OPCODE;

   // Memory models: the word at address p is 0xA0+p (BIOS) or 0xB000+p (OS).
   assign BIOS_INSTRUCTION = {bios_op, 26'(32'h0A0 + 32'(PC))};
   assign OS_INSTRUCTION   = 32'hB000 + 32'(PC);

   instruction_fetch_switch #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10),
      .BIOS_ENTRY_ADDRESS(10'h000), .OS_ENTRY_ADDRESS(10'h100),
      .FLUSH_CYCLES(2), .NOP_INSTRUCTION(32'h0)
   ) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .instruction_selection(sel),
      .BIOS_INSTRUCTION(BIOS_INSTRUCTION), .OS_INSTRUCTION(OS_INSTRUCTION),
      .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
      .PC(PC), .INSTRUCTION(INSTRUCTION), .INSTRUCTION_VALID(INSTRUCTION_VALID),
      .BIOS_INSTRUCTION_OPCODE(BIOS_INSTRUCTION_OPCODE),
      .HANDOFF_BUSY(HANDOFF_BUSY), .HANDOFF_DONE(HANDOFF_DONE)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [9:0]  pc;
      logic [31:0] ins;
      logic        v;
      logic        b;
      logic        d;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_no  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_pc"},    32'(PC), 32'h0);
      chk({tag, "_instr"}, INSTRUCTION, 32'h0);
      chk({tag, "_vld"},   32'(INSTRUCTION_VALID), 32'h0);
      chk({tag, "_busy"},  32'(HANDOFF_BUSY), 32'h0);
      chk({tag, "_done"},  32'(HANDOFF_DONE), 32'h0);
   endtask

   // Drive inputs at a falling edge, queue the outputs expected after the next rising edge.
   task automatic step(input logic s, input logic st, input logic br, input logic [9:0] tgt,
                       input logic [9:0] pc, input logic [31:0] ins,
                       input logic v, input logic b, input logic d);
      exp_t e;
      sel = s; STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
      e.pc = pc; e.ins = ins; e.v = v; e.b = b; e.d = d;
      exp_q.push_back(e);
      @(negedge CLOCK);
   endtask

   always @(posedge CLOCK) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         step_no++;
         chk($sformatf("s%0d_pc", step_no),    32'(PC), 32'(mon_e.pc));
         chk($sformatf("s%0d_instr", step_no), INSTRUCTION, mon_e.ins);
         chk($sformatf("s%0d_vld", step_no),   32'(INSTRUCTION_VALID), 32'(mon_e.v));
         chk($sformatf("s%0d_busy", step_no),  32'(HANDOFF_BUSY), 32'(mon_e.b));
         chk($sformatf("s%0d_done", step_no),  32'(HANDOFF_DONE), 32'(mon_e.d));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      #2 RESET_N = 1'b0;
      #1 reset_chk("rst_init");
      bios_op = 6'h2B;
      #1 chk("opcode", 32'(BIOS_INSTRUCTION_OPCODE), 32'h2B);
      bios_op = 6'h00;
      @(negedge CLOCK);
      RESET_N = 1'b1;

      // BIOS sequential fetch
      step(0,0,0,10'h000, 10'h001, 32'h0A0, 1,0,0);
      step(0,0,0,10'h000, 10'h002, 32'h0A1, 1,0,0);
      step(0,0,0,10'h000, 10'h003, 32'h0A2, 1,0,0);
      step(0,0,0,10'h000, 10'h004, 32'h0A3, 1,0,0);
      step(0,0,0,10'h000, 10'h005, 32'h0A4, 1,0,0);
      // handoff at PC=5 with a simultaneous branch, stall during flush
      step(1,0,1,10'h055, 10'h100, 32'h0, 0,1,0);
      step(1,1,1,10'h055, 10'h100, 32'h0, 0,1,0);
      step(1,1,0,10'h000, 10'h100, 32'h0, 0,0,1);
      // OS run; selection dropping is ignored
      step(0,0,0,10'h000, 10'h101, 32'hB100, 1,0,0);
      step(0,0,0,10'h000, 10'h102, 32'hB101, 1,0,0);
      // branch to the last address, squash bubble, then wrap
      step(0,0,1,10'h3FF, 10'h3FF, 32'h0, 0,0,0);
      step(0,0,0,10'h000, 10'h000, 32'hB3FF, 1,0,0);
      step(0,0,0,10'h000, 10'h001, 32'hB000, 1,0,0);
      // stall beats branch for 3 cycles, branch lands when stall drops
      for (int i = 0; i < 3; i++) step(0,1,1,10'h020, 10'h001, 32'hB000, 1,0,0);
      step(0,0,1,10'h020, 10'h020, 32'h0, 0,0,0);
      step(0,0,0,10'h000, 10'h021, 32'hB020, 1,0,0);

      // reset from OS_RUN
      RESET_N = 1'b0;
      #1 reset_chk("rst_os");
      @(negedge CLOCK);
      RESET_N = 1'b1;
      step(1,0,0,10'h000, 10'h100, 32'h0, 0,1,0);
      // reset mid-flush with selection dropped
      RESET_N = 1'b0; sel = 1'b0;
      #1 reset_chk("rst_flush");
      repeat (2) @(negedge CLOCK);
      RESET_N = 1'b1;
      step(0,0,0,10'h000, 10'h001, 32'h0A0, 1,0,0);
      step(0,0,0,10'h000, 10'h002, 32'h0A1, 1,0,0);
      step(0,0,0,10'h000, 10'h003, 32'h0A2, 1,0,0);
      step(0,1,0,10'h000, 10'h003, 32'h0A2, 1,0,0);

      // selection already high at the first edge after release restarts handoff
      RESET_N = 1'b0;
      #1 reset_chk("rst_restart");
      @(negedge CLOCK);
      RESET_N = 1'b1;
      step(1,0,0,10'h000, 10'h100, 32'h0, 0,1,0);
      step(1,0,0,10'h000, 10'h100, 32'h0, 0,1,0);
      step(1,0,0,10'h000, 10'h100, 32'h0, 0,0,1);
      step(0,0,0,10'h000, 10'h101, 32'hB100, 1,0,0);

      @(negedge CLOCK);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_switch.md
INSTRUCTION_FETCH_SWITCH -- requirements
Module: instruction_fetch_switch

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, the instruction word width.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 10, the program counter width.
REQ-003 The block SHALL expose parameter BIOS_ENTRY_ADDRESS, default 0, the PC value loaded at reset.
REQ-004 The block SHALL expose parameter OS_ENTRY_ADDRESS, default 0, the PC value loaded on BIOS-to-OS handoff.
REQ-005 The block SHALL expose parameter FLUSH_CYCLES, default 2, range 1..15, the number of bubble cycles inserted on handoff.
REQ-006 The block SHALL expose parameter NOP_INSTRUCTION, default all-zero, the word driven during bubbles and after reset.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-008 Port: CLOCK  input  1  rising-edge clock.
REQ-009 Port: RESET_N  input  1  asynchronous active-low reset.
REQ-010 Port: instruction_selection  input  1  source select from the OS control unit; 0 = BIOS, 1 = OS.
REQ-011 Port: BIOS_INSTRUCTION  input  DATA_WIDTH  word read from BIOS memory at PC.
REQ-012 Port: OS_INSTRUCTION  input  DATA_WIDTH  word read from OS memory at PC.
REQ-013 Port: STALL  input  1  freeze PC and instruction register.
REQ-014 Port: BRANCH_TAKEN  input  1  load PC from BRANCH_TARGET.
REQ-015 Port: BRANCH_TARGET  input  ADDR_WIDTH  branch destination.
REQ-016 Port: PC  output  ADDR_WIDTH  registered fetch address to both memories.
REQ-017 Port: INSTRUCTION  output  DATA_WIDTH  registered fetched word to decode.
REQ-018 Port: INSTRUCTION_VALID  output  1  INSTRUCTION holds a real fetched word.
REQ-019 Port: BIOS_INSTRUCTION_OPCODE  output  6  BIOS_INSTRUCTION[DATA_WIDTH-1:DATA_WIDTH-6], combinational, fed to the OS control unit.
REQ-020 Port: HANDOFF_BUSY  output  1  high while in FLUSH.
REQ-021 Port: HANDOFF_DONE  output  1  one-cycle registered pulse on entry to OS_RUN.

Function
REQ-022 The block SHALL implement states BIOS_RUN, FLUSH, OS_RUN.
REQ-023 BIOS_RUN with instruction_selection=1 SHALL go to FLUSH next cycle, load PC=OS_ENTRY_ADDRESS, load the bubble counter with FLUSH_CYCLES-1; STALL and BRANCH_TAKEN ignored that cycle.
REQ-024 FLUSH SHALL decrement the counter each cycle regardless of STALL; at counter 0 go to OS_RUN and assert HANDOFF_DONE for exactly one cycle.
REQ-025 OS_RUN SHALL be terminal until reset; instruction_selection returning to 0 SHALL be ignored.
REQ-026 In BIOS_RUN/OS_RUN: STALL=1 holds PC, INSTRUCTION, INSTRUCTION_VALID; STALL takes priority over BRANCH_TAKEN.
REQ-027 In BIOS_RUN/OS_RUN with STALL=0: BRANCH_TAKEN=1 loads PC=BRANCH_TARGET, else PC increments by 1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-028 With STALL=0, INSTRUCTION SHALL register BIOS_INSTRUCTION in BIOS_RUN or OS_INSTRUCTION in OS_RUN, with INSTRUCTION_VALID=1; latency one cycle from the PC presented.
REQ-029 A taken branch SHALL cause the next INSTRUCTION to be NOP_INSTRUCTION with INSTRUCTION_VALID=0 (one squash bubble).
REQ-030 During FLUSH, INSTRUCTION SHALL be NOP_INSTRUCTION, INSTRUCTION_VALID=0, PC held at OS_ENTRY_ADDRESS, BRANCH_TAKEN ignored.
REQ-031 HANDOFF_BUSY SHALL be 1 exactly in FLUSH cycles (FLUSH_CYCLES cycles total).

Reset
REQ-032 RESET_N=0 SHALL immediately force state BIOS_RUN, PC=BIOS_ENTRY_ADDRESS, INSTRUCTION=NOP_INSTRUCTION, INSTRUCTION_VALID=0, HANDOFF_BUSY=0, HANDOFF_DONE=0, counter=0.
REQ-033 Reset asserted mid-FLUSH or in OS_RUN SHALL abort to the REQ-032 values; if instruction_selection is 1 at the first edge after release, handoff SHALL restart per REQ-023.

Verification
REQ-034 Reset release, selection=0, BIOS words 0xA0..0xA3 -> PC 0,1,2,3; INSTRUCTION 0xA0.. one cycle after each PC, VALID=1 from second cycle.
REQ-035 Selection rises at PC=5, OS_ENTRY_ADDRESS=0x100, FLUSH_CYCLES=2 -> PC=0x100, BUSY high 2 cycles with NOP/VALID=0, DONE one pulse, then OS words with PC 0x101, 0x102.
REQ-036 BRANCH_TAKEN with target 0x3FF in OS_RUN, no stall -> PC=0x3FF, one invalid bubble, next PC=0x000 (wrap).
REQ-037 STALL=1 and BRANCH_TAKEN=1 together for 3 cycles -> PC, INSTRUCTION, VALID unchanged; branch taken only when STALL drops with BRANCH_TAKEN still 1.
REQ-038 Selection=1 with BRANCH_TAKEN=1 same cycle, then STALL=1 in FLUSH -> PC=OS_ENTRY_ADDRESS, FLUSH still ends after FLUSH_CYCLES, branch discarded.
REQ-039 RESET_N low mid-FLUSH, then selection dropped to 0 -> outputs at REQ-032 values immediately, BIOS fetch resumes from BIOS_ENTRY_ADDRESS, no DONE pulse.
